// File: rtl/ctrl_pkg.sv
// Shared constants for the multi-cycle RV32I controller: opcodes, state
// encoding, ALUOp codes and the decoded opcode-class payload.
package ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_DECODE  = 3'd2;
    localparam logic [2:0] S_EXEC    = 3'd3;
    localparam logic [2:0] S_MEM     = 3'd4;
    localparam logic [2:0] S_IO_WAIT = 3'd5;
    localparam logic [2:0] S_WB      = 3'd6;
    localparam logic [2:0] S_TRAP    = 3'd7;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_CMP   = 2'b01;
    localparam logic [1:0] ALUOP_ARITH = 2'b10;

    // One-hot instruction class; all-zero means the opcode is not supported.
    typedef struct packed {
        logic r;
        logic i;
        logic load;
        logic store;
        logic branch;
        logic jal;
        logic jalr;
        logic lui;
        logic auipc;
    } op_class_t;

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bus between the multi-cycle controller (master) and the
// instruction register / datapath / memory / I/O side (slave).
interface multicycle_controller_if #(
    parameter int unsigned ADDR_HI_W = 22
);
    logic [6:0]           opcode;
    logic [ADDR_HI_W-1:0] Alu_resultHigh;
    logic                 io_ack;

    logic                 pc_write;
    logic                 ir_write;
    logic                 Branch;
    logic                 Jump;
    logic                 MemRead;
    logic                 MemWrite;
    logic                 MemtoReg;
    logic                 RegWrite;
    logic                 ALUSrc;
    logic [1:0]           ALUOp;
    logic                 IORead;
    logic                 IOWrite;
    logic                 io_req;
    logic                 instr_done;
    logic                 illegal_op;
    logic [2:0]           state;

    modport master (
        input  opcode, Alu_resultHigh, io_ack,
        output pc_write, ir_write, Branch, Jump, MemRead, MemWrite, MemtoReg,
               RegWrite, ALUSrc, ALUOp, IORead, IOWrite, io_req, instr_done,
               illegal_op, state
    );

    modport slave (
        output opcode, Alu_resultHigh, io_ack,
        input  pc_write, ir_write, Branch, Jump, MemRead, MemWrite, MemtoReg,
               RegWrite, ALUSrc, ALUOp, IORead, IOWrite, io_req, instr_done,
               illegal_op, state
    );
endinterface

// File: rtl/opcode_classifier.sv
// Combinational RV32I opcode decoder: one-hot class plus legal flag.
module opcode_classifier
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output op_class_t  op_class,
    output logic       legal
);

    always_comb begin
        op_class = '0;
        case (opcode)
            OP_R:      op_class.r      = 1'b1;
            OP_I:      op_class.i      = 1'b1;
            OP_LOAD:   op_class.load   = 1'b1;
            OP_STORE:  op_class.store  = 1'b1;
            OP_BRANCH: op_class.branch = 1'b1;
            OP_JAL:    op_class.jal    = 1'b1;
            OP_JALR:   op_class.jalr   = 1'b1;
            OP_LUI:    op_class.lui    = 1'b1;
            OP_AUIPC:  op_class.auipc  = 1'b1;
            default:   ;
        endcase
        legal = |op_class;
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the RV32I core: sequences fetch/decode/execute/
// memory/write-back, routes high-address accesses through a timed I/O handshake.
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int unsigned          ADDR_HI_W  = 22,
    parameter logic [ADDR_HI_W-1:0] IO_PREFIX  = '1,
    parameter int unsigned          IO_TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    multicycle_controller_if.master   bus
);

    localparam int unsigned       CNT_W    = $clog2(IO_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(IO_TIMEOUT - 1);

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [6:0]       opc_q;
    logic [CNT_W-1:0] tmo_cnt;
    logic [CNT_W-1:0] tmo_nxt;
    logic [6:0]       cls_opcode;
    op_class_t        cls;
    logic             legal;
    logic             io_hit;

    // Live opcode is only needed for the legality decision in DECODE.
    assign cls_opcode = (state == S_DECODE) ? bus.opcode : opc_q;
    assign io_hit     = (bus.Alu_resultHigh == IO_PREFIX);

    opcode_classifier u_classifier (
        .opcode   (cls_opcode),
        .op_class (cls),
        .legal    (legal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            opc_q   <= '0;
            tmo_cnt <= '0;
        end else begin
            state   <= state_nxt;
            tmo_cnt <= tmo_nxt;
            if (state == S_DECODE) begin
                opc_q <= bus.opcode;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        tmo_nxt        = '0;
        bus.pc_write   = 1'b0;
        bus.ir_write   = 1'b0;
        bus.Branch     = 1'b0;
        bus.Jump       = 1'b0;
        bus.MemRead    = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.MemtoReg   = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.ALUSrc     = 1'b0;
        bus.ALUOp      = ALUOP_ADD;
        bus.IORead     = 1'b0;
        bus.IOWrite    = 1'b0;
        bus.io_req     = 1'b0;
        bus.instr_done = 1'b0;
        bus.illegal_op = 1'b0;
        bus.state      = state;

        // ALU controls follow the latched opcode from EXEC until the instruction retires.
        if (state == S_EXEC || state == S_MEM || state == S_IO_WAIT || state == S_WB) begin
            bus.ALUSrc = cls.i | cls.load | cls.store | cls.jalr | cls.lui | cls.auipc;
            if (cls.r || cls.i) begin
                bus.ALUOp = ALUOP_ARITH;
            end else if (cls.branch) begin
                bus.ALUOp = ALUOP_CMP;
            end
        end

        case (state)
            S_IDLE: begin
                state_nxt = S_FETCH;
            end
            S_FETCH: begin
                bus.MemRead  = 1'b1;
                bus.ir_write = 1'b1;
                state_nxt    = S_DECODE;
            end
            S_DECODE: begin
                state_nxt = legal ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                if (cls.branch) begin
                    bus.Branch     = 1'b1;
                    bus.pc_write   = 1'b1;
                    bus.instr_done = 1'b1;
                    state_nxt      = S_FETCH;
                end else if (cls.load || cls.store) begin
                    state_nxt = S_MEM;
                end else begin
                    state_nxt = S_WB;
                end
            end
            S_MEM: begin
                if (io_hit) begin
                    state_nxt = S_IO_WAIT;
                end else if (cls.load) begin
                    bus.MemRead = 1'b1;
                    state_nxt   = S_WB;
                end else begin
                    bus.MemWrite   = 1'b1;
                    bus.pc_write   = 1'b1;
                    bus.instr_done = 1'b1;
                    state_nxt      = S_FETCH;
                end
            end
            S_IO_WAIT: begin
                bus.io_req  = 1'b1;
                bus.IORead  = cls.load;
                bus.IOWrite = cls.store;
                tmo_nxt     = tmo_cnt + CNT_W'(1);
                // An ack arriving in the final allowed cycle still completes the access.
                if (bus.io_ack) begin
                    if (cls.load) begin
                        state_nxt = S_WB;
                    end else begin
                        bus.pc_write   = 1'b1;
                        bus.instr_done = 1'b1;
                        state_nxt      = S_FETCH;
                    end
                end else if (tmo_cnt == CNT_LAST) begin
                    state_nxt = S_TRAP;
                end
            end
            S_WB: begin
                bus.RegWrite   = 1'b1;
                bus.pc_write   = 1'b1;
                bus.instr_done = 1'b1;
                bus.MemtoReg   = cls.load;
                bus.Jump       = cls.jal | cls.jalr;
                state_nxt      = S_FETCH;
            end
            S_TRAP: begin
                bus.illegal_op = 1'b1;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: each instruction is expanded
// into its expected per-cycle control trace and compared cycle by cycle.
module tb_multicycle_controller;

    localparam int unsigned AW  = 22;
    localparam int unsigned TMO = 4;

    typedef struct packed {
        logic [2:0] st;
        logic       pc_write;
        logic       ir_write;
        logic       branch;
        logic       jump;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       io_read;
        logic       io_write;
        logic       io_req;
        logic       instr_done;
        logic       illegal_op;
    } vec_t;

    typedef struct {
        vec_t v;
        logic ack;
        logic is_dec;
        logic is_mem;
        logic is_io;
    } step_t;

    typedef enum int {C_R, C_I, C_LOAD, C_STORE, C_BR, C_JAL, C_JALR, C_LUI, C_AUIPC, C_BAD} cls_e;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;
    step_t steps[$];
    logic  trap_end;

    logic [6:0] ops [12] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                            7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                            7'b0010111, 7'b1111111, 7'b0000000, 7'b1110011};

    always #5 clk = ~clk;

    multicycle_controller_if #(.ADDR_HI_W(AW)) bus ();

    multicycle_controller #(
        .ADDR_HI_W  (AW),
        .IO_PREFIX  ({AW{1'b1}}),
        .IO_TIMEOUT (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic vec_t observe();
        vec_t v;
        v.st         = bus.state;
        v.pc_write   = bus.pc_write;
        v.ir_write   = bus.ir_write;
        v.branch     = bus.Branch;
        v.jump       = bus.Jump;
        v.mem_read   = bus.MemRead;
        v.mem_write  = bus.MemWrite;
        v.mem_to_reg = bus.MemtoReg;
        v.reg_write  = bus.RegWrite;
        v.alu_src    = bus.ALUSrc;
        v.alu_op     = bus.ALUOp;
        v.io_read    = bus.IORead;
        v.io_write   = bus.IOWrite;
        v.io_req     = bus.io_req;
        v.instr_done = bus.instr_done;
        v.illegal_op = bus.illegal_op;
        return v;
    endfunction

    function automatic cls_e classify(input logic [6:0] op);
        case (op)
            7'b0110011: return C_R;
            7'b0010011: return C_I;
            7'b0000011: return C_LOAD;
            7'b0100011: return C_STORE;
            7'b1100011: return C_BR;
            7'b1101111: return C_JAL;
            7'b1100111: return C_JALR;
            7'b0110111: return C_LUI;
            7'b0010111: return C_AUIPC;
            default:    return C_BAD;
        endcase
    endfunction

    function automatic step_t mk(input vec_t v, input logic ack, input logic dec,
                                 input logic mem, input logic io);
        step_t s;
        s.v = v; s.ack = ack; s.is_dec = dec; s.is_mem = mem; s.is_io = io;
        return s;
    endfunction

    // Expected trace of one instruction from its class, address space and ack timing.
    task automatic build(input logic [6:0] op, input logic io, input int ack_at);
        cls_e c = classify(op);
        vec_t base = '0;
        vec_t v;
        logic do_wb = 1'b0;
        logic acked = 1'b0;
        steps.delete();
        trap_end = 1'b0;
        base.alu_src = (c inside {C_I, C_LOAD, C_STORE, C_JALR, C_LUI, C_AUIPC});
        base.alu_op  = (c == C_R || c == C_I) ? 2'b10 : (c == C_BR) ? 2'b01 : 2'b00;

        v = '0; v.st = 3'd1; v.mem_read = 1'b1; v.ir_write = 1'b1;
        steps.push_back(mk(v, 1'b0, 1'b0, 1'b0, 1'b0));
        v = '0; v.st = 3'd2;
        steps.push_back(mk(v, 1'b0, 1'b1, 1'b0, 1'b0));
        if (c == C_BAD) begin
            trap_end = 1'b1;
        end else begin
            v = base; v.st = 3'd3;
            if (c == C_BR) begin
                v.branch = 1'b1; v.pc_write = 1'b1; v.instr_done = 1'b1;
            end
            steps.push_back(mk(v, 1'b0, 1'b0, 1'b0, 1'b0));
            if (c == C_LOAD || c == C_STORE) begin
                v = base; v.st = 3'd4;
                if (!io && c == C_LOAD) begin
                    v.mem_read = 1'b1; do_wb = 1'b1;
                end else if (!io) begin
                    v.mem_write = 1'b1; v.pc_write = 1'b1; v.instr_done = 1'b1;
                end
                steps.push_back(mk(v, 1'b0, 1'b0, 1'b1, 1'b0));
                if (io) begin
                    for (int k = 1; k <= int'(TMO) && !acked; k++) begin
                        v = base; v.st = 3'd5; v.io_req = 1'b1;
                        v.io_read = (c == C_LOAD); v.io_write = (c == C_STORE);
                        acked = (k == ack_at);
                        if (acked && c == C_STORE) begin
                            v.pc_write = 1'b1; v.instr_done = 1'b1;
                        end
                        steps.push_back(mk(v, acked, 1'b0, 1'b0, 1'b1));
                    end
                    if (!acked) trap_end = 1'b1;
                    else if (c == C_LOAD) do_wb = 1'b1;
                end
            end else if (c != C_BR) begin
                do_wb = 1'b1;
            end
        end
        if (trap_end) begin
            for (int k = 0; k < 3; k++) begin
                v = '0; v.st = 3'd7; v.illegal_op = 1'b1;
                steps.push_back(mk(v, 1'b0, 1'b0, 1'b0, 1'b0));
            end
        end else if (do_wb) begin
            v = base; v.st = 3'd6; v.reg_write = 1'b1; v.pc_write = 1'b1;
            v.instr_done = 1'b1; v.mem_to_reg = (c == C_LOAD);
            v.jump = (c == C_JAL || c == C_JALR);
            steps.push_back(mk(v, 1'b0, 1'b0, 1'b0, 1'b0));
        end
    endtask

    // Asynchronous reset from mid-cycle; returns just after release, in IDLE.
    task automatic do_reset();
        rst = 1'b1;
        #1 check("rst_async", 32'(observe()), 32'd0);
        repeat (3) begin
            @(negedge clk);
            bus.io_ack = 1'($urandom);
            bus.opcode = 7'($urandom);
            #1 check("rst_hold", 32'(observe()), 32'd0);
        end
        rst = 1'b0;
        #1 check("idle", 32'(observe()), 32'd0);
    endtask

    task automatic run(input string name, input logic [6:0] op, input logic [AW-1:0] addr,
                       input int ack_at, input int max_steps);
        logic io = (addr == {AW{1'b1}});
        int n;
        build(op, io, ack_at);
        n = (steps.size() < max_steps) ? steps.size() : max_steps;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.opcode         = steps[i].is_dec ? op : 7'($urandom);
            bus.Alu_resultHigh = steps[i].is_mem ? addr : AW'($urandom);
            bus.io_ack         = steps[i].is_io ? steps[i].ack : 1'($urandom);
            #1 check($sformatf("%s[%0d]", name, i), 32'(observe()), 32'(steps[i].v));
        end
        if (trap_end || n < steps.size()) do_reset();
    endtask

    initial begin
        logic [6:0]    op;
        logic [AW-1:0] addr;
        rst                = 1'b1;
        bus.opcode         = '0;
        bus.Alu_resultHigh = '0;
        bus.io_ack         = 1'b0;
        do_reset();

        run("add",       7'b0110011, 22'h000010, 0, 99);
        run("lw_mem",    7'b0000011, 22'h000010, 0, 99);
        run("sw_mem",    7'b0100011, 22'h000123, 0, 99);
        run("beq",       7'b1100011, 22'h000000, 0, 99);
        run("jal",       7'b1101111, 22'h3FFFFF, 0, 99);
        run("sw_io_ack3", 7'b0100011, 22'h3FFFFF, 3, 99);
        run("lw_io_tmo", 7'b0000011, 22'h3FFFFF, 0, 99);
        run("lw_io_ack4", 7'b0000011, 22'h3FFFFF, 4, 99);
        run("lw_io_ack1", 7'b0000011, 22'h3FFFFF, 1, 99);
        run("illegal",   7'b1111111, 22'h000000, 0, 99);
        run("abort",     7'b0110011, 22'h000000, 0, 2);
        run("after_abort", 7'b0110111, 22'h000000, 0, 99);

        for (int t = 0; t < 120; t++) begin
            op   = ops[$urandom_range(0, 11)];
            addr = ($urandom_range(0, 1) == 1) ? {AW{1'b1}} : AW'($urandom_range(0, 32'h1FFFFF));
            run($sformatf("rnd%0d", t), op, addr, int'($urandom_range(0, TMO + 1)),
                ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 5)) : 99);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Parametrised multi-cycle control FSM for the RV32I core, replacing the single-cycle combinational main decoder. It sequences every instruction through fetch/decode/execute/memory/write-back states and classifies memory or I/O addresses from the ALU result high bits. It runs an `io_req`/`io_ack` handshake with a timeout toward I/O devices and traps on illegal opcodes. It sits between the instruction register and the datapath/memory/I/O mux.

## Interface
Parameters:
- `ADDR_HI_W`, 22: width of `Alu_resultHigh` (ALU result bits [31:32-ADDR_HI_W]).
- `IO_PREFIX`, all-ones of `ADDR_HI_W`: high-address value that selects I/O space.
- `IO_TIMEOUT`, 255: max cycles in `IO_WAIT` without `io_ack` before trapping (≥1).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `opcode`  in  7  instr[6:0] from IR; valid in DECODE.
- `Alu_resultHigh`  in  ADDR_HI_W  ALU result high bits; sampled in MEM.
- `io_ack`  in  1  device completion strobe.
- `pc_write`, `ir_write`  out  1  PC update / IR load enables.
- `Branch`, `Jump`  out  1  branch-compare PC select / unconditional PC select.
- `MemRead`, `MemWrite`, `MemtoReg`, `RegWrite`, `ALUSrc`  out  1  datapath controls.
- `ALUOp`  out  2  10 arith, 00 add, 01 compare.
- `IORead`, `IOWrite`, `io_req`  out  1  I/O access controls.
- `instr_done`  out  1  pulse in final cycle of each instruction.
- `illegal_op`  out  1  high while in TRAP.
- `state`  out  3  current state (debug).

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, IO_WAIT=5, WB=6, TRAP=7. `rst` forces IDLE; IDLE→FETCH unconditionally.
- FETCH: `MemRead`=1, `ir_write`=1 → DECODE.
- DECODE: latch `opcode` into `opc_q`. Classes: R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111. Any other opcode → TRAP; otherwise → EXEC.
- EXEC: BRANCH asserts `Branch`, `pc_write`, `instr_done` → FETCH. LOAD/STORE → MEM. All other classes → WB.
- MEM: `io_hit` = (`Alu_resultHigh` == `IO_PREFIX`).
  - `io_hit`: → IO_WAIT.
  - Memory LOAD: `MemRead`=1 → WB.
  - Memory STORE: `MemWrite`=1, `pc_write`, `instr_done` → FETCH.
- IO_WAIT: `io_req`=1, plus `IORead` (LOAD) or `IOWrite` (STORE), held until exit.
  - `io_ack`: LOAD → WB; STORE → FETCH with `pc_write`, `instr_done`.
  - Timeout counter clears on entry and increments on each cycle without ack. At `IO_TIMEOUT` without ack → TRAP. Ack in the same cycle wins.
- WB: `RegWrite`=1, `pc_write`=1, `instr_done`=1. `MemtoReg`=1 for LOAD. `Jump`=1 for JAL/JALR → FETCH.
- TRAP: sticky until `rst`. Only `illegal_op`=1; all other outputs 0.
- `ALUSrc`/`ALUOp` are decoded from `opc_q` and held from EXEC until `instr_done`; they are 0 in IDLE/FETCH/DECODE/TRAP.
  - `ALUSrc`=1 for I, LOAD, STORE, JALR, LUI, AUIPC.
  - `ALUOp`: 10 for R/I, 01 for BRANCH, 00 otherwise.

## Timing
- Reset: state=IDLE; every output 0; `state`=0; timeout counter 0; `opc_q`=0. Reset mid-instruction aborts immediately with no further strobes.
- Cycles per instruction: BRANCH 3; R/I/JAL/JALR/LUI/AUIPC 4; memory STORE 4; memory LOAD 5. I/O LOAD is 5+N and I/O STORE 4+N, where N is the number of IO_WAIT cycles (≥1).
- All outputs are Moore (a function of state and `opc_q`), except:
  - `io_hit`-dependent MEM outputs.
  - IO_WAIT exit strobes, which depend on `io_ack`.
- `io_ack` outside IO_WAIT is ignored.

## Structure
- `ctrl_pkg` holds the opcode constants, state encoding, and ALUOp codes.
- Sub-module `opcode_classifier` (combinational): `opcode` → one-hot class plus `legal`. It is used at DECODE and on `opc_q`.

## Test plan
- Hold `rst` high for 3 cycles, then release → all outputs 0 during reset; `state` 0→1 on the first edge after release.
- `add` (0110011) → states 1,2,3,6; `ALUOp`=10 and `ALUSrc`=0 in EXEC; `RegWrite`, `pc_write`, `instr_done` pulse in WB.
- `lw` with `Alu_resultHigh`=22'h000010 → 5 cycles; `MemRead` in MEM; `MemtoReg`/`RegWrite` in WB; `IORead`=0.
- `sw` with `Alu_resultHigh`=22'h3FFFFF, `io_ack` after 3 cycles → `IOWrite`/`io_req` high for exactly 3 IO_WAIT cycles; `instr_done` on the ack cycle; no `RegWrite`.
- `lw` to I/O with `IO_TIMEOUT`=4 and no ack → TRAP after 4 IO_WAIT cycles; `illegal_op` stays 1 until `rst`. Repeat with ack on cycle 4 → WB, not TRAP.
- Opcode 7'b1111111 → TRAP after DECODE; no `pc_write`; `state`=7.
